// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and defaults for the adder arbiter
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int N_REQ_DEF = 4;
    localparam int A_W_DEF   = 4;

    // One extra bit so the carry out of the adder is never lost.
    function automatic int sum_w(input int a_w);
        return a_w + 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// rtl/adder_arbiter_rr_picker.sv - combinational round-robin picker
module rr_picker
    import adder_arb_pkg::*;
#(
    parameter int  N_REQ = N_REQ_DEF,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_ptr,
    output logic             found,
    output logic [IDW-1:0]   grant
);

    // Scan from the farthest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (req[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one external adder between requesters
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int  N_REQ = N_REQ_DEF,
    parameter int  A_W   = A_W_DEF,
    localparam int S_W   = sum_w(A_W),
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0][A_W-1:0] req_a,
    input  logic [N_REQ-1:0][A_W-1:0] req_b,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [S_W-1:0]            rsp_sum,
    output logic [A_W-1:0]            add_a,
    output logic [A_W-1:0]            add_b,
    input  logic [S_W-1:0]            add_c,
    output logic                      busy,
    output logic [IDW-1:0]            grant_id
);

    state_e         state, state_n;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick;
    logic           found;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (found),
        .grant  (pick)
    );

    assign busy = (state != IDLE);

    always_comb begin
        req_ready = '0;
        state_n   = state;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[pick] = 1'b1;
                    state_n         = EXEC;
                end
            end
            EXEC:    state_n = RESP;
            RESP:    if (rsp_ready[grant_id]) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_sum   <= '0;
            add_a     <= '0;
            add_b     <= '0;
            grant_id  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                add_a    <= req_a[pick];
                add_b    <= req_b[pick];
                grant_id <= pick;
                rr_ptr   <= (pick == IDW'(N_REQ - 1)) ? '0 : pick + IDW'(1);
            end
            if (state == EXEC) begin
                rsp_sum   <= add_c;
                rsp_valid <= N_REQ'(1) << grant_id;
            end
            if (state == RESP && rsp_ready[grant_id]) begin
                rsp_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_ready));
            assert ($onehot0(rsp_valid));
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (|rsp_valid && !rsp_ready[grant_id]) |=> $stable(rsp_sum));

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;

    localparam int N_REQ = 4;
    localparam int A_W   = 4;
    localparam int S_W   = 5;
    localparam int IDW   = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ-1:0][A_W-1:0] req_a;
    logic [N_REQ-1:0][A_W-1:0] req_b;
    logic [N_REQ-1:0]          rsp_valid;
    logic [N_REQ-1:0]          rsp_ready;
    logic [S_W-1:0]            rsp_sum;
    logic [A_W-1:0]            add_a;
    logic [A_W-1:0]            add_b;
    logic [S_W-1:0]            add_c;
    logic                      busy;
    logic [IDW-1:0]            grant_id;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared adder.
    assign add_c = {1'b0, add_a} + {1'b0, add_b};

    adder_arbiter #(.N_REQ(N_REQ), .A_W(A_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // One full operation from IDLE with rsp_ready already high; 3 cycles.
    task automatic do_op(input int g, input int sum);
        #1;
        chk("op_req_ready", 32'(req_ready), 32'(1) << g);
        tick;
        chk("op_busy_exec", 32'(busy), 1);
        chk("op_grant", 32'(grant_id), g);
        chk("op_rsp_idle", 32'(rsp_valid), 0);
        tick;
        chk("op_rsp_valid", 32'(rsp_valid), 32'(1) << g);
        chk("op_rsp_sum", 32'(rsp_sum), sum);
        tick;
        chk("op_busy_done", 32'(busy), 0);
        chk("op_rsp_clear", 32'(rsp_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_add_b", 32'(add_b), 0);
        chk("rst_req_ready", 32'(req_ready), 0);

        // Single request 6+4 on requester 0, one cycle of back-pressure.
        tick;
        req_valid = 4'b0001;
        req_a[0]  = 4'd6;
        req_b[0]  = 4'd4;
        #1;
        chk("t1_req_ready", 32'(req_ready), 4'b0001);
        chk("t1_busy_idle", 32'(busy), 0);
        tick;
        req_valid = '0;
        #1;
        chk("t1_busy_exec", 32'(busy), 1);
        chk("t1_add_a", 32'(add_a), 6);
        chk("t1_add_b", 32'(add_b), 4);
        chk("t1_no_rsp", 32'(rsp_valid), 0);
        tick;
        chk("t1_rsp_valid", 32'(rsp_valid), 4'b0001);
        chk("t1_rsp_sum", 32'(rsp_sum), 10);
        chk("t1_busy_resp", 32'(busy), 1);
        tick;
        chk("t1_busy_hold", 32'(busy), 1);
        rsp_ready = 4'b0001;
        tick;
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_rsp_clear", 32'(rsp_valid), 0);

        // Overflow: 15+15 on requester 2 (rr_ptr is 1).
        rsp_ready = 4'b1111;
        req_valid = 4'b0100;
        req_a[2]  = 4'd15;
        req_b[2]  = 4'd15;
        do_op(2, 30);

        // Wrap-around: grant 3, then 1001 gives 0 then 3.
        req_valid = 4'b1000;
        req_a[3]  = 4'd1;
        req_b[3]  = 4'd2;
        do_op(3, 3);
        req_valid = 4'b1001;
        req_a[0]  = 4'd5;
        req_b[0]  = 4'd7;
        do_op(0, 12);
        do_op(3, 3);

        // All four requesting continuously with operands (i,i).
        req_valid = 4'b1111;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i] = A_W'(i);
            req_b[i] = A_W'(i);
        end
        do_op(0, 0);
        do_op(1, 2);
        do_op(2, 4);
        do_op(3, 6);
        do_op(0, 0);

        // Back-pressure on requester 1 while requester 3 waits.
        req_valid = 4'b1010;
        req_a[1]  = 4'd9;
        req_b[1]  = 4'd8;
        rsp_ready = 4'b1000;
        #1;
        chk("bp_req_ready", 32'(req_ready), 4'b0010);
        tick;
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 4'b0010);
            chk("bp_rsp_sum", 32'(rsp_sum), 17);
            chk("bp_req_ready_blk", 32'(req_ready), 0);
            tick;
        end
        rsp_ready = 4'b0010;
        tick;
        rsp_ready = 4'b1111;
        #1;
        chk("bp_idle_rsp", 32'(rsp_valid), 0);
        chk("bp_idle_ready3", 32'(req_ready), 4'b1000);
        tick;
        chk("bp_grant3", 32'(grant_id), 3);
        tick;
        chk("bp_rsp3_valid", 32'(rsp_valid), 4'b1000);
        chk("bp_rsp3_sum", 32'(rsp_sum), 6);
        tick;

        // Reset during RESP after granting requester 1 (rr_ptr would be 2).
        req_valid = 4'b0010;
        rsp_ready = '0;
        tick;
        req_valid = '0;
        tick;
        chk("rr_rsp_pre", 32'(rsp_valid), 4'b0010);
        chk("rr_sum_pre", 32'(rsp_sum), 17);
        rst = 1'b1;
        tick;
        rst       = 1'b0;
        req_valid = 4'b0110;
        #1;
        chk("rr_rsp_valid", 32'(rsp_valid), 0);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_sum", 32'(rsp_sum), 0);
        chk("rr_add_a", 32'(add_a), 0);
        chk("rr_req_ready", 32'(req_ready), 4'b0010);
        tick;
        chk("rr_grant", 32'(grant_id), 1);
        chk("rr_busy_exec", 32'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
